// File: rtl/key_event_decoder.sv
// Key event decoder: turns a debounced key level into one-cycle click,
// double-click, long-press and auto-repeat events for the time-set logic.
module key_event_decoder #(
    parameter int LONG_CYC = 50_000_000,
    parameter int REP_CYC  = 10_000_000,
    parameter int DBL_CYC  = 15_000_000,
    parameter int CNT_W    = 26
) (
    input  logic clk,
    input  logic rst,
    input  logic key_level,
    output logic click,
    output logic dbl_click,
    output logic long_press,
    output logic repeat_evt,
    output logic key_busy
);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] PRESS1   = 3'd1;
    localparam logic [2:0] GAP      = 3'd2;
    localparam logic [2:0] HOLD     = 3'd3;
    localparam logic [2:0] WAIT_REL = 3'd4;

    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYC - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REP_CYC - 1);
    localparam logic [CNT_W-1:0] DBL_LAST  = CNT_W'(DBL_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic [2:0]       state;
    logic [2:0]       nextState;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] nextCnt;
    logic             clickNext;
    logic             dblNext;
    logic             longNext;
    logic             repNext;

    // Next-state, timer and event decode from the current state and key level
    always_comb begin
        nextState = state;
        nextCnt   = cnt;
        clickNext = 1'b0;
        dblNext   = 1'b0;
        longNext  = 1'b0;
        repNext   = 1'b0;
        case (state)
            IDLE: begin
                if (key_level) nextState = PRESS1;
            end
            PRESS1: begin
                if (!key_level) begin
                    nextState = GAP;
                end else if (cnt == LONG_LAST) begin
                    nextState = HOLD;
                    longNext  = 1'b1;
                end else begin
                    nextCnt = cnt + CNT_ONE;
                end
            end
            GAP: begin
                if (key_level) begin
                    // A second press, even a long one, only ever reports dbl_click
                    nextState = WAIT_REL;
                    dblNext   = 1'b1;
                end else if (cnt == DBL_LAST) begin
                    nextState = IDLE;
                    clickNext = 1'b1;
                end else begin
                    nextCnt = cnt + CNT_ONE;
                end
            end
            HOLD: begin
                if (!key_level) begin
                    nextState = IDLE;
                end else if (cnt == REP_LAST) begin
                    repNext = 1'b1;
                    nextCnt = '0;
                end else begin
                    nextCnt = cnt + CNT_ONE;
                end
            end
            WAIT_REL: begin
                if (!key_level) nextState = IDLE;
            end
            default: begin
                nextState = IDLE;
            end
        endcase
        // Every state change restarts the timer for the new state
        if (nextState != state) nextCnt = '0;
    end

    // State, timer and registered event outputs; reset parks in WAIT_REL so a
    // key held across reset is swallowed until released
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= WAIT_REL;
            cnt        <= '0;
            click      <= 1'b0;
            dbl_click  <= 1'b0;
            long_press <= 1'b0;
            repeat_evt <= 1'b0;
            key_busy   <= 1'b0;
        end else begin
            state      <= nextState;
            cnt        <= nextCnt;
            click      <= clickNext;
            dbl_click  <= dblNext;
            long_press <= longNext;
            repeat_evt <= repNext;
            key_busy   <= (nextState != IDLE);
        end
    end

endmodule

// File: tb/tb_key_event_decoder.sv
// Directed bench for key_event_decoder with short timer parameters
// (LONG_CYC=20, REP_CYC=5, DBL_CYC=8). Edge numbers are counted from 1
// after each stats clear; an event decided at edge N is logged as N.
module tb_key_event_decoder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic key_level = 1'b0;
    logic click, dbl_click, long_press, repeat_evt, key_busy;

    int errors = 0;
    int checks = 0;

    int cyc;
    int nClick, nDbl, nLong, nRep, nMulti;
    int tClick, tDbl, tLong, tBusyFall;
    int tRep[$];
    logic busyPrev;

    key_event_decoder #(
        .LONG_CYC(20),
        .REP_CYC (5),
        .DBL_CYC (8),
        .CNT_W   (5)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .key_level (key_level),
        .click     (click),
        .dbl_click (dbl_click),
        .long_press(long_press),
        .repeat_evt(repeat_evt),
        .key_busy  (key_busy)
    );

    always #5 clk = ~clk;

    task automatic clearStats();
        cyc = 0;
        nClick = 0; nDbl = 0; nLong = 0; nRep = 0;
        tClick = -1; tDbl = -1; tLong = -1; tBusyFall = -1;
        tRep.delete();
        busyPrev = key_busy;
    endtask

    // Apply one key level, take one clock edge, log any pulses seen after it
    task automatic tick(input logic k);
        key_level = k;
        @(posedge clk);
        #1;
        cyc++;
        if (click)      begin nClick++; tClick = cyc; end
        if (dbl_click)  begin nDbl++;   tDbl   = cyc; end
        if (long_press) begin nLong++;  tLong  = cyc; end
        if (repeat_evt) begin nRep++;   tRep.push_back(cyc); end
        if ((int'(click) + int'(dbl_click) + int'(long_press) + int'(repeat_evt)) > 1) nMulti++;
        if (busyPrev && !key_busy && tBusyFall < 0) tBusyFall = cyc;
        busyPrev = key_busy;
    endtask

    task automatic ticks(input logic k, input int n);
        for (int i = 0; i < n; i++) tick(k);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ticks(1'b0, 3);
        checks++;
        if ({click, dbl_click, long_press, repeat_evt, key_busy} !== 5'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b want 00000",
                     {click, dbl_click, long_press, repeat_evt, key_busy});
        end
        rst = 1'b0;
        tick(1'b0);
        checks++;
        if (key_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_busy: got %b want 0", key_busy);
        end
    endtask

    task automatic test_click();
        clearStats();
        ticks(1'b1, 5);          // edges 1..5, release sampled at edge 6
        ticks(1'b0, 12);
        checks++;
        if (nClick !== 1 || tClick !== 14) begin
            errors++;
            $display("FAIL click_timing: got count %0d at %0d want 1 at 14", nClick, tClick);
        end
        checks++;
        if (nDbl + nLong + nRep !== 0) begin
            errors++;
            $display("FAIL click_other_events: got %0d want 0", nDbl + nLong + nRep);
        end
        checks++;
        if (tBusyFall !== 14) begin
            errors++;
            $display("FAIL click_busy_fall: got %0d want 14", tBusyFall);
        end
    endtask

    task automatic test_dbl_click();
        clearStats();
        ticks(1'b1, 3);          // edges 1..3
        ticks(1'b0, 3);          // edges 4..6 in GAP
        ticks(1'b1, 30);         // second press sampled at edge 7
        ticks(1'b0, 12);         // release sampled at edge 37
        checks++;
        if (nDbl !== 1 || tDbl !== 7) begin
            errors++;
            $display("FAIL dbl_timing: got count %0d at %0d want 1 at 7", nDbl, tDbl);
        end
        checks++;
        if (nClick + nLong + nRep !== 0) begin
            errors++;
            $display("FAIL dbl_other_events: got %0d want 0", nClick + nLong + nRep);
        end
        checks++;
        if (tBusyFall !== 37) begin
            errors++;
            $display("FAIL dbl_busy_fall: got %0d want 37", tBusyFall);
        end
    endtask

    task automatic test_long_repeat();
        int r0, r1, r2;
        clearStats();
        ticks(1'b1, 37);         // entry edge 1, held through edge 37
        ticks(1'b0, 12);         // release sampled at edge 38
        r0 = (tRep.size() > 0) ? tRep[0] : -1;
        r1 = (tRep.size() > 1) ? tRep[1] : -1;
        r2 = (tRep.size() > 2) ? tRep[2] : -1;
        checks++;
        if (nLong !== 1 || tLong !== 21) begin
            errors++;
            $display("FAIL long_timing: got count %0d at %0d want 1 at 21", nLong, tLong);
        end
        checks++;
        if (nRep !== 3) begin
            errors++;
            $display("FAIL repeat_count: got %0d want 3", nRep);
        end
        checks++;
        if (r0 !== 26 || r1 !== 31 || r2 !== 36) begin
            errors++;
            $display("FAIL repeat_times: got %0d,%0d,%0d want 26,31,36", r0, r1, r2);
        end
        checks++;
        if (nClick + nDbl !== 0) begin
            errors++;
            $display("FAIL hold_release_event: got %0d want 0", nClick + nDbl);
        end
        checks++;
        if (tBusyFall !== 38) begin
            errors++;
            $display("FAIL hold_busy_fall: got %0d want 38", tBusyFall);
        end
    endtask

    task automatic test_long_boundary();
        // One cycle short of long: 20 sampled-high edges, release at edge 21
        clearStats();
        ticks(1'b1, 20);
        ticks(1'b0, 12);
        checks++;
        if (nClick !== 1 || tClick !== 29 || nLong !== 0) begin
            errors++;
            $display("FAIL short_boundary: got click %0d at %0d long %0d want 1 at 29 long 0",
                     nClick, tClick, nLong);
        end
        // Exactly long: 21 sampled-high edges, release at edge 22
        clearStats();
        ticks(1'b1, 21);
        ticks(1'b0, 12);
        checks++;
        if (nLong !== 1 || tLong !== 21) begin
            errors++;
            $display("FAIL long_boundary: got count %0d at %0d want 1 at 21", nLong, tLong);
        end
        checks++;
        if (nClick + nRep + nDbl !== 0) begin
            errors++;
            $display("FAIL long_boundary_other: got %0d want 0", nClick + nRep + nDbl);
        end
    endtask

    task automatic test_held_through_reset();
        clearStats();
        rst = 1'b1;
        ticks(1'b1, 3);
        checks++;
        if (key_busy !== 1'b0) begin
            errors++;
            $display("FAIL held_reset_busy: got %b want 0", key_busy);
        end
        rst = 1'b0;
        tick(1'b1);
        checks++;
        if (key_busy !== 1'b1) begin
            errors++;
            $display("FAIL held_release_busy: got %b want 1", key_busy);
        end
        ticks(1'b1, 25);
        tick(1'b0);
        checks++;
        if (nClick + nDbl + nLong + nRep !== 0 || key_busy !== 1'b0) begin
            errors++;
            $display("FAIL held_ignored: got events %0d busy %b want 0 busy 0",
                     nClick + nDbl + nLong + nRep, key_busy);
        end
        clearStats();
        ticks(1'b1, 3);          // release sampled at edge 4
        ticks(1'b0, 12);
        checks++;
        if (nClick !== 1 || tClick !== 12) begin
            errors++;
            $display("FAIL held_then_click: got count %0d at %0d want 1 at 12", nClick, tClick);
        end
    endtask

    task automatic test_reset_in_hold();
        clearStats();
        ticks(1'b1, 27);         // long at 21, repeat at 26
        rst = 1'b1;
        tick(1'b1);              // edge 28
        checks++;
        if ({click, dbl_click, long_press, repeat_evt, key_busy} !== 5'b0) begin
            errors++;
            $display("FAIL hold_reset_outputs: got %b want 00000",
                     {click, dbl_click, long_press, repeat_evt, key_busy});
        end
        rst = 1'b0;
        ticks(1'b1, 15);         // old schedule would repeat at 31, 36, 41
        checks++;
        if (nLong !== 1 || nRep !== 1) begin
            errors++;
            $display("FAIL hold_reset_discard: got long %0d repeat %0d want 1 and 1", nLong, nRep);
        end
        tick(1'b0);
        clearStats();
        ticks(1'b1, 26);         // fresh: long at 21, repeat at 26
        ticks(1'b0, 4);
        checks++;
        if (nLong !== 1 || tLong !== 21 || nRep !== 1 || (tRep.size() > 0 ? tRep[0] : -1) !== 26) begin
            errors++;
            $display("FAIL fresh_hold: got long %0d at %0d repeat %0d want long 1 at 21 repeat 1 at 26",
                     nLong, tLong, nRep);
        end
    endtask

    initial begin
        nMulti = 0;
        clearStats();
        test_reset();
        test_click();
        test_dbl_click();
        test_long_repeat();
        test_long_boundary();
        test_held_through_reset();
        test_reset_in_hold();
        checks++;
        if (nMulti !== 0) begin
            errors++;
            $display("FAIL single_event_per_cycle: got %0d multi-pulse cycles want 0", nMulti);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
